// File: rtl/pipeline_stall_ctrl.sv
// Hazard stall/flush consumer: per-stage write enables and squash controls.
// Optional perf counters built only when PIPE_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_STALL    = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             flush_req,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             stall_active,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] STALL_LIM  = 8'(MAX_STALL - 1);

  state_t     state, state_nxt;
  logic [7:0] stall_cnt, stall_cnt_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic       do_flush, do_hold, do_stall;

  // One-hot selects encode the fixed priority order
  assign do_flush = !rst && flush_req;
  assign do_hold  = !rst && !flush_req && (state == FLUSH);
  assign do_stall = !rst && !flush_req && (state != FLUSH)
                    && stall_req;

  always_comb begin
    state_nxt      = state;
    stall_cnt_nxt  = stall_cnt;
    flush_cnt_nxt  = flush_cnt;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    stall_active   = 1'b0;
    unique case (1'b1)
      rst: begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
        state_nxt      = RUN;
        stall_cnt_nxt  = '0;
        flush_cnt_nxt  = '0;
      end
      do_flush: begin
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        flush_cnt_nxt = FLUSH_LOAD;
        stall_cnt_nxt = '0;
        state_nxt     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end
      do_hold: begin
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        flush_cnt_nxt = flush_cnt - 3'd1;
        state_nxt     = (flush_cnt <= 3'd1) ? RUN : FLUSH;
      end
      do_stall: begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_flush    = 1'b1;
        stall_active   = 1'b1;
        state_nxt      = STALL;
        if (stall_cnt != 8'hff)
          stall_cnt_nxt = stall_cnt + 8'd1;
      end
      default: begin
        state_nxt     = RUN;
        stall_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    state     <= state_nxt;
    stall_cnt <= stall_cnt_nxt;
    flush_cnt <= flush_cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_timeout <= 1'b0;
    else if (do_stall && stall_cnt == STALL_LIM)
      stall_timeout <= 1'b1;
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (do_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (do_flush && flush_events != '1)
        flush_events <= flush_events + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl.
// Two instances differ only in FLUSH_CYCLES (2 and 3).
module tb_pipeline_stall_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_req = 1'b0;
  logic flush_req = 1'b0;

  logic pc2, ifw2, iff2, idf2, sa2, to2;
  logic pc3, ifw3, iff3, idf3, sa3, to3;
  logic [31:0] sc2, fe2, sc3, fe3;
  logic [4:0] ctl2, ctl3;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .MAX_STALL(4)) dut2 (
    .clk(clk), .rst(rst),
    .stall_req(stall_req), .flush_req(flush_req),
    .pc_write_en(pc2), .if_id_write_en(ifw2),
    .if_id_flush(iff2), .id_ex_flush(idf2),
    .stall_active(sa2), .stall_timeout(to2),
    .stall_cycles(sc2), .flush_events(fe2)
  );

  pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .MAX_STALL(4)) dut3 (
    .clk(clk), .rst(rst),
    .stall_req(stall_req), .flush_req(flush_req),
    .pc_write_en(pc3), .if_id_write_en(ifw3),
    .if_id_flush(iff3), .id_ex_flush(idf3),
    .stall_active(sa3), .stall_timeout(to3),
    .stall_cycles(sc3), .flush_events(fe3)
  );

  // {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, stall_active}
  assign ctl2 = {pc2, ifw2, iff2, idf2, sa2};
  assign ctl3 = {pc3, ifw3, iff3, idf3, sa3};

  localparam logic [4:0] C_RST = 5'b00110;
  localparam logic [4:0] C_RUN = 5'b11000;
  localparam logic [4:0] C_STL = 5'b00011;
  localparam logic [4:0] C_FLS = 5'b11110;

  // Drive one cycle's inputs just after the edge, then let outputs settle
  task automatic step(input logic r, input logic s, input logic f);
    @(posedge clk);
    #1;
    rst = r;
    stall_req = s;
    flush_req = f;
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (ctl2 !== C_RST)
      $display("FAIL reset_ctl got %b want %b", ctl2, C_RST);
    else passed++;
    total++;
    if (to2 !== 1'b0 || sc2 !== 32'd0 || fe2 !== 32'd0)
      $display("FAIL reset_regs got to=%b sc=%0d fe=%0d want 0 0 0",
               to2, sc2, fe2);
    else passed++;
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (ctl2 !== C_RUN)
      $display("FAIL post_reset_run got %b want %b", ctl2, C_RUN);
    else passed++;
  endtask

  task automatic test_single_stall;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    total++;
    if (ctl2 !== C_STL)
      $display("FAIL single_stall got %b want %b", ctl2, C_STL);
    else passed++;
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (ctl2 !== C_RUN)
      $display("FAIL stall_release got %b want %b", ctl2, C_RUN);
    else passed++;
    total++;
    if (sc2 !== 32'(PERF) || fe2 !== 32'd0)
      $display("FAIL stall_count got sc=%0d fe=%0d want sc=%0d fe=0",
               sc2, fe2, PERF);
    else passed++;
  endtask

  task automatic test_timeout;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0);
      total++;
      if (ctl2 !== C_STL || to2 !== 1'b0)
        $display("FAIL timeout_stall%0d got ctl=%b to=%b want %b 0",
                 i, ctl2, to2, C_STL);
      else passed++;
    end
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (to2 !== 1'b1 || ctl2 !== C_RUN)
      $display("FAIL timeout_rise got to=%b ctl=%b want 1 %b",
               to2, ctl2, C_RUN);
    else passed++;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (to2 !== 1'b1 || sc2 !== 32'(4 * PERF))
      $display("FAIL timeout_sticky got to=%b sc=%0d want 1 %0d",
               to2, sc2, 4 * PERF);
    else passed++;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (to2 !== 1'b0)
      $display("FAIL timeout_clear got %b want 0", to2);
    else passed++;
  endtask

  task automatic test_flush_priority;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    total++;
    if (ctl2 !== C_FLS)
      $display("FAIL flush_prio_c0 got %b want %b", ctl2, C_FLS);
    else passed++;
    step(1'b0, 1'b1, 1'b0);
    total++;
    if (ctl2 !== C_FLS)
      $display("FAIL flush_prio_c1 got %b want %b", ctl2, C_FLS);
    else passed++;
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (ctl2 !== C_RUN)
      $display("FAIL flush_prio_c2 got %b want %b", ctl2, C_RUN);
    else passed++;
    total++;
    if (fe2 !== 32'(PERF) || sc2 !== 32'd0)
      $display("FAIL flush_prio_cnt got fe=%0d sc=%0d want fe=%0d sc=0",
               fe2, sc2, PERF);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [5:0] fpat;
    logic [4:0] want;
    fpat = 6'b000101;
    step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0, fpat[c]);
      want = (c < 5) ? C_FLS : C_RUN;
      total++;
      if (ctl3 !== want)
        $display("FAIL b2b_c%0d got %b want %b", c, ctl3, want);
      else passed++;
    end
    total++;
    if (fe3 !== 32'(2 * PERF))
      $display("FAIL b2b_events got %0d want %0d", fe3, 2 * PERF);
    else passed++;
  endtask

  task automatic test_reset_mid_stall;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (ctl2 !== C_RST)
      $display("FAIL mid_rst got %b want %b", ctl2, C_RST);
    else passed++;
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (ctl2 !== C_RUN || sc2 !== 32'd0)
      $display("FAIL mid_rst_run got ctl=%b sc=%0d want %b 0",
               ctl2, sc2, C_RUN);
    else passed++;
  endtask

  task automatic test_reset_mid_flush;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    total++;
    if (ctl3 !== C_STL)
      $display("FAIL mid_flush_rst got %b want %b", ctl3, C_STL);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_single_stall;
    test_timeout;
    test_flush_priority;
    test_back_to_back;
    test_reset_mid_stall;
    test_reset_mid_flush;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
